// File: rtl/main_control_unit.sv
// Purpose     : RV32I main decoder, opcode -> registered datapath control bundle.
// Latency     : 1 cycle from opcode sample to outputs; 1 opcode per cycle.
// Backpressure: none; no stall input, upstream holds opcode to repeat a bundle.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; outputs become an all-zero NOP bundle
//   opcode    instruction bits [6:0]
//   RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump, Lui, Illegal
//             single-bit control strobes
//   ALUOp     2-bit ALU class: 00 add, 01 branch compare, 10 R-type, 11 I-type
module main_control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemToReg,
    output logic       ALUSrc,
    output logic       Branch,
    output logic [1:0] ALUOp,
    output logic       Jump,
    output logic       Lui,
    output logic       Illegal
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       lui;
        logic       illegal;
    } ctrl_t;

    ctrl_t ctrl_nxt;
    ctrl_t ctrl_q;

    // Decode. Any opcode outside the table, including one carrying X/Z bits
    // (which matches no case item), falls to the default and flags Illegal
    // with every other strobe quiet, so an unknown instruction can never
    // write the register file or touch memory.
    always_comb begin
        ctrl_nxt = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_nxt.reg_write = 1'b1;
                ctrl_nxt.alu_op    = 2'b10;
            end
            OP_ITYPE: begin
                ctrl_nxt.alu_src   = 1'b1;
                ctrl_nxt.reg_write = 1'b1;
                ctrl_nxt.alu_op    = 2'b11;
            end
            OP_LOAD: begin
                ctrl_nxt.alu_src    = 1'b1;
                ctrl_nxt.mem_to_reg = 1'b1;
                ctrl_nxt.reg_write  = 1'b1;
                ctrl_nxt.mem_read   = 1'b1;
            end
            OP_STORE: begin
                ctrl_nxt.alu_src   = 1'b1;
                ctrl_nxt.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_nxt.branch = 1'b1;
                ctrl_nxt.alu_op = 2'b01;
            end
            OP_JAL: begin
                ctrl_nxt.reg_write = 1'b1;
                ctrl_nxt.jump      = 1'b1;
            end
            OP_LUI: begin
                // Immediate goes through the ALU with operand A forced to zero.
                ctrl_nxt.alu_src   = 1'b1;
                ctrl_nxt.reg_write = 1'b1;
                ctrl_nxt.lui       = 1'b1;
            end
            default: begin
                ctrl_nxt.illegal = 1'b1;
            end
        endcase
    end

    // Reset wins over decode on the same edge, squashing the in-flight opcode
    // into a NOP bundle (Illegal also 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_nxt;
        end
    end

    // Outputs come straight from the flops; no combinational opcode path.
    assign ALUSrc   = ctrl_q.alu_src;
    assign MemToReg = ctrl_q.mem_to_reg;
    assign RegWrite = ctrl_q.reg_write;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign Branch   = ctrl_q.branch;
    assign ALUOp    = ctrl_q.alu_op;
    assign Jump     = ctrl_q.jump;
    assign Lui      = ctrl_q.lui;
    assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_main_control_unit.sv
// Purpose     : self-checking bench for main_control_unit (scoreboard style).
// Latency     : expects each bundle one rising edge after its opcode is driven.
// Backpressure: none; stimulus pushes expectations, monitor pops every cycle.
module tb_main_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       RegWrite, MemRead, MemWrite, MemToReg, ALUSrc;
    logic       Branch, Jump, Lui, Illegal;
    logic [1:0] ALUOp;

    main_control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemToReg (MemToReg),
        .ALUSrc   (ALUSrc),
        .Branch   (Branch),
        .ALUOp    (ALUOp),
        .Jump     (Jump),
        .Lui      (Lui),
        .Illegal  (Illegal)
    );

    // Bundle order: ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch,
    // ALUOp[1:0], Jump, Lui, Illegal -- written out by hand from the decode table.
    localparam logic [10:0] B_NOP = 11'b0_0_0_0_0_0_00_0_0_0;
    localparam logic [10:0] B_R   = 11'b0_0_1_0_0_0_10_0_0_0;
    localparam logic [10:0] B_I   = 11'b1_0_1_0_0_0_11_0_0_0;
    localparam logic [10:0] B_LD  = 11'b1_1_1_1_0_0_00_0_0_0;
    localparam logic [10:0] B_ST  = 11'b1_0_0_0_1_0_00_0_0_0;
    localparam logic [10:0] B_BR  = 11'b0_0_0_0_0_1_01_0_0_0;
    localparam logic [10:0] B_JAL = 11'b0_0_1_0_0_0_00_1_0_0;
    localparam logic [10:0] B_LUI = 11'b1_0_1_0_0_0_00_0_1_0;
    localparam logic [10:0] B_ILL = 11'b0_0_0_0_0_0_00_0_0_1;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    int errors = 0;
    int checks = 0;

    logic [10:0] exp_q[$];
    string       name_q[$];
    logic [10:0] last_exp;

    function automatic logic [10:0] ref_decode(input logic [6:0] op);
        case (op)
            OP_R:    return B_R;
            OP_I:    return B_I;
            OP_LD:   return B_LD;
            OP_ST:   return B_ST;
            OP_BR:   return B_BR;
            OP_JAL:  return B_JAL;
            OP_LUI:  return B_LUI;
            default: return B_ILL;
        endcase
    endfunction

    function automatic logic [10:0] dut_bundle();
        return {ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch,
                ALUOp, Jump, Lui, Illegal};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge; the DUT samples on the next rising edge.
    task automatic drive(input logic r, input logic [6:0] op, input string nm);
        logic [10:0] e;
        @(negedge clk);
        rst    = r;
        opcode = op;
        e = r ? B_NOP : ref_decode(op);
        exp_q.push_back(e);
        name_q.push_back(nm);
        last_exp = e;
    endtask

    // Monitor: outputs are presented every cycle; sample 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (dut_bundle() !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b", nm, dut_bundle(), e);
            end
            checks++;
            if (MemRead && MemWrite) begin
                errors++;
                $display("FAIL %s memrd_memwr_excl: got MemRead=%b MemWrite=%b expected not both 1",
                         nm, MemRead, MemWrite);
            end
            checks++;
            if (RegWrite && Illegal) begin
                errors++;
                $display("FAIL %s regwr_on_illegal: got RegWrite=%b Illegal=%b expected RegWrite=0",
                         nm, RegWrite, Illegal);
            end
        end
    end

    initial begin
        logic [6:0] legal_ops [7];
        logic [6:0] op;
        legal_ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_LUI};
        rst      = 1'b1;
        opcode   = OP_R;
        last_exp = B_NOP;

        // Reset held for two edges with an R-type opcode, then release.
        drive(1'b1, OP_R, "reset_0");
        drive(1'b1, OP_R, "reset_1");
        drive(1'b0, OP_R, "post_reset_r");

        // Back-to-back sweep of the legal opcodes.
        drive(1'b0, OP_R,   "sweep_r");
        drive(1'b0, OP_I,   "sweep_i");
        drive(1'b0, OP_LD,  "sweep_load");
        drive(1'b0, OP_ST,  "sweep_store");
        drive(1'b0, OP_BR,  "sweep_branch");
        drive(1'b0, OP_JAL, "sweep_jal");
        drive(1'b0, OP_LUI, "sweep_lui");

        // Illegal opcodes, JALR included.
        drive(1'b0, 7'b1111111, "illegal_7f");
        drive(1'b0, 7'b0000000, "illegal_00");
        drive(1'b0, 7'b1100111, "illegal_jalr");

        // Glitch between edges: outputs must hold the previous bundle
        // (illegal_jalr) until the edge, then show Store.
        begin
            logic [10:0] hold;
            hold = last_exp;
            drive(1'b0, OP_ST, "glitch_store");
            #1 opcode = 7'b1111111;
            #1;
            checks++;
            if (dut_bundle() !== hold) begin
                errors++;
                $display("FAIL glitch_hold_a: got %b expected %b", dut_bundle(), hold);
            end
            #1 opcode = OP_ST;
            #1;
            checks++;
            if (dut_bundle() !== hold) begin
                errors++;
                $display("FAIL glitch_hold_b: got %b expected %b", dut_bundle(), hold);
            end
        end

        // Reset mid-stream squashes the Load sampled on the same edge.
        drive(1'b0, OP_I,  "stream_i");
        drive(1'b0, OP_JAL, "stream_jal");
        drive(1'b1, OP_LD, "midreset_squash");
        drive(1'b0, OP_LD, "midreset_release_load");

        // Random stream: half legal, half arbitrary bit patterns.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(1, 0) == 1)
                op = legal_ops[$urandom_range(6, 0)];
            else
                op = 7'($urandom());
            drive(1'b0, op, "random");
        end

        // Let the monitor drain the last expectation, bounded to a few cycles.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/main_control_unit.md
# main_control_unit

Main decoder of the single-issue RV32I core. It translates the 7-bit instruction opcode into the datapath control strobes: register write, memory read/write, write-back select, ALU operand select, branch, jump, LUI and the 2-bit ALUOp consumed by the ALU control unit. Outputs are registered, so the block sits between the fetch/decode register and the execute stage with one cycle of latency.

## Interface
Parameters: none. All widths are fixed by the RV32I encoding.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  7  instruction bits [6:0]
- `RegWrite`  out  1  write the rd register file entry
- `MemRead`  out  1  data memory read enable
- `MemWrite`  out  1  data memory write enable
- `MemToReg`  out  1  write-back source: 1 = memory data, 0 = ALU result
- `ALUSrc`  out  1  ALU operand B: 1 = immediate, 0 = rs2
- `Branch`  out  1  conditional branch instruction
- `ALUOp`  out  2  00 = add, 01 = branch compare/subtract, 10 = R-type funct decode, 11 = I-type ALU funct decode
- `Jump`  out  1  JAL; write-back selects PC+4 and the PC takes the jump target
- `Lui`  out  1  LUI; the datapath forces ALU operand A to zero
- `Illegal`  out  1  opcode not in the supported set

## Operation
Decode is combinational on `opcode`, and the result is registered. Fields are listed as ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Jump, Lui, Illegal.
- R-type 0110011: 0,0,1,0,0,0,10,0,0,0
- I-type ALU 0010011: 1,0,1,0,0,0,11,0,0,0
- Load 0000011: 1,1,1,1,0,0,00,0,0,0
- Store 0100011: 1,0,0,0,1,0,00,0,0,0
- Branch 1100011: 0,0,0,0,0,1,01,0,0,0
- JAL 1101111: 0,0,1,0,0,0,00,1,0,0
- LUI 0110111: 1,0,1,0,0,0,00,0,1,0
- Any other opcode, including any X/Z bit: every output 0 and ALUOp=00, except Illegal=1.

Invariants:
- MemRead and MemWrite are never both 1.
- RegWrite=0 whenever Illegal=1.
- Exactly one of {R, I, Load, Store, Branch, JAL, LUI, Illegal} classes is active per decode.
- Don't-care fields are driven 0 as tabulated, never left undefined.

## Timing
- Rising edge with `rst`=1: all outputs go to 0, including ALUOp=00 and Illegal=0. This is a NOP bundle.
- `rst` has priority over decode on the same edge. Asserting reset mid-stream squashes the in-flight decode on that edge.
- Rising edge with `rst`=0: outputs take the decode of the `opcode` sampled at that edge. Latency is exactly 1 cycle, and throughput is 1 opcode per cycle.
- Outputs are held stable between edges. Opcode glitches between edges have no effect.
- Outputs come directly from flops, with no combinational path from `opcode` to outputs.
- After reset deasserts, the first valid bundle appears one edge after the first sampled opcode.
- There is no handshake or stall input. The upstream stage must hold `opcode` for as long as it wants the bundle repeated.

## Test plan
- Reset: hold `rst`=1 for 2 edges with opcode=0110011. Required: all outputs 0, Illegal=0. Then deassert `rst`. Required: one edge later RegWrite=1, ALUOp=10, all other outputs 0.
- Sweep all seven legal opcodes back-to-back, one per cycle (R, I, Load, Store, Branch, JAL, LUI). Required: each bundle matches the decode list exactly one cycle after its opcode is applied. Example: Load gives ALUSrc=1, MemToReg=1, RegWrite=1, MemRead=1, ALUOp=00.
- Illegal opcodes 1111111, 0000000 and 1100111 (JALR, unsupported). Required: Illegal=1, all other outputs 0, ALUOp=00.
- Change `opcode` between edges from 0100011 to 1111111 and back before the next edge. Required: outputs unchanged until the edge, then reflect 0100011 (MemWrite=1, ALUSrc=1).
- Assert `rst` in the same cycle opcode=0000011 is applied after a running stream. Required: next edge gives all zeros. Deassert and keep opcode. Required: the following edge gives the Load bundle.
- Random opcodes for 1000 cycles. Required: MemRead&MemWrite never 1, RegWrite never 1 while Illegal=1, and the registered output equals the reference decode of the previous cycle's opcode.
